// File: rtl/set_exec_unit.sv
// Two-stage execute unit for DLX set instructions (SEQ/SNE/SLT/SGT/SLE/SGE).
// Operands and the result use [0:31] numbering, so bit 0 is the sign bit.
module set_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [0:31] in_a,
    input  logic [0:31] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] out_result,
    output logic        out_err,
    output logic [15:0] true_count
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_SNE = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_SGT = 3'b011;
    localparam logic [2:0] OP_SLE = 3'b100;
    localparam logic [2:0] OP_SGE = 3'b101;

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_op_q, s1_op_d;
    logic [0:31] s1_a_q, s1_a_d;
    logic [0:31] s1_b_q, s1_b_d;
    logic        out_valid_q, out_valid_d;
    logic [0:31] out_result_q, out_result_d;
    logic        out_err_q, out_err_d;
    logic [15:0] true_count_q, true_count_d;

    logic        s2_free;
    logic        in_fire;
    logic        out_fire;
    logic [0:32] diff;
    logic        a_lt_b;
    logic        a_eq_b;
    logic        cond;
    logic        illegal;

    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Sign of the 33-bit sign-extended difference gives A < B without overflow.
    assign diff   = {s1_a_q[0], s1_a_q} - {s1_b_q[0], s1_b_q};
    assign a_lt_b = diff[0];
    assign a_eq_b = (s1_a_q == s1_b_q);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (s1_op_q)
            OP_SEQ:  cond = a_eq_b;
            OP_SNE:  cond = !a_eq_b;
            OP_SLT:  cond = a_lt_b;
            OP_SGT:  cond = !a_lt_b && !a_eq_b;
            OP_SLE:  cond = a_lt_b || a_eq_b;
            OP_SGE:  cond = !a_lt_b;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
        end else if (s2_free) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 only moves when it is free; otherwise the presented result is frozen.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = {31'd0, cond && !illegal};
                out_err_d    = illegal;
            end
        end
    end

    always_comb begin
        true_count_d = true_count_q;
        if (out_fire && (out_result_q == 32'd1)) begin
            true_count_d = true_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 3'b000;
            s1_a_q       <= 32'd0;
            s1_b_q       <= 32'd0;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_err_q    <= 1'b0;
            true_count_q <= 16'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            true_count_q <= true_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign true_count = true_count_q;

endmodule

// File: doc/set_exec_unit.md
# set_exec_unit

Pipelined execute-stage block for DLX set instructions (SEQ, SNE, SLT, SGT, SLE, SGE). It accepts an operand pair plus a set opcode over a valid/ready handshake and returns the 32-bit architectural result over a second valid/ready handshake. The result is 32'h00000001 when the condition holds and 32'h00000000 otherwise. It sits between operand fetch and register writeback, and is the consumer-side counterpart of the combinational comparison flags inside the ALU. It has a two-stage pipeline with full backpressure and a completed-true counter.

## Interface
- No parameters. Data width is fixed at 32 bits, big-endian numbered [0:31], with bit 0 as the MSB/sign bit.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  an operand/op triple is presented
- in_ready  out  1  the block can accept a triple this cycle
- in_op  in  3  set opcode:
  - 000 SEQ, 001 SNE, 010 SLT, 011 SGT, 100 SLE, 101 SGE
  - 110 and 111 are illegal
- in_a  in  [0:31]  operand A
- in_b  in  [0:31]  operand B
- out_valid  out  1  a result is presented
- out_ready  in  1  downstream takes the result this cycle
- out_result  out  [0:31]  32'h00000001 if the condition is true, else 32'h00000000
- out_err  out  1  the op was illegal; out_result is 0 in that case
- true_count  out  16  count of completed results equal to 1; wraps from 16'hFFFF to 0

## Operation
- All comparisons are signed two's complement. A < B is evaluated as the sign of the 33-bit difference A − B, sign-extended, so there is no overflow error.
  - Example: A=7FFFFFFF, B=FFFFFFFF gives SGT=1 and SLT=0.
- Stage 1 (S1) registers s1_valid, op, A and B.
- Stage 2 (S2) computes the result from the S1 registers and registers out_valid, out_result and out_err.
- Input transfer occurs on a rising edge with in_valid && in_ready.
- Output transfer occurs on a rising edge with out_valid && out_ready.
- Readiness rules:
  - s2_free = !out_valid || out_ready
  - in_ready = !s1_valid || s2_free
- S1 → S2 advance: when s1_valid && s2_free, S2 loads the computed result and out_valid becomes 1.
- If s2_free but S1 is empty, out_valid clears on the output transfer.
- S1 load and S1 → S2 advance in the same cycle are legal; this gives 1 result per cycle at steady state.
- While out_valid && !out_ready, out_result and out_err are held stable and S2 does not change.
  - S1 may still accept exactly one triple, after which in_ready falls.
- No value is dropped or duplicated.
- in_a, in_b and in_op are sampled only on an input transfer; their values are don't-care otherwise.
- Illegal op: out_result = 0, out_err = 1, and the pipeline continues normally.
- true_count increments by 1 on each output transfer with out_result = 1, and wraps modulo 2^16.
- Simultaneous in/out transfers on a full pipeline are legal and both take effect.

## Timing
- Reset values (synchronous; applied at the edge where reset = 1):
  - s1_valid = 0
  - out_valid = 0
  - out_result = 0
  - out_err = 0
  - true_count = 0
- in_ready is combinational and equals 1 in the cycle after reset.
- Reset mid-operation discards both in-flight entries. No output transfer occurs on the reset edge, and true_count does not increment on it.
- Latency: a triple accepted at edge N has out_valid = 1 in the cycle following edge N+1, given no stall.
  - Minimum latency is 2 edges from acceptance to consumption.
- Throughput is 1 result per cycle when out_ready is held at 1.
- in_ready depends combinationally on out_ready. out_valid and out_result do not depend combinationally on any input.
- Pipeline capacity is 2 entries. With out_ready = 0 from empty, exactly 2 triples are accepted, then in_ready = 0.

## Test plan
- Reset, then send A=22, B=22 for each op 000..101 back-to-back with out_ready = 1:
  - results in order are 1,0,0,0,1,1
  - out_valid is high for 6 consecutive cycles starting 2 edges after the first accept
  - true_count = 3
- Signed boundary: A=7FFFFFFF, B=FFFFFFFF with SGT → 1 and SLT → 0. A=FFFFFFFF, B=7FFFFFFF with SLT → 1. A=80000000, B=7FFFFFFF with SGT → 0.
- Backpressure: hold out_ready = 0 and offer 4 triples (A=22, B=21, SGT):
  - only 2 are accepted, and in_ready = 0 afterwards
  - out_result = 1 holds stable
  - releasing out_ready drains 2 results, then the remaining 2 are accepted
  - final true_count = 4
- Illegal op 110 with A=0, B=0: out_result = 0, out_err = 1, and true_count is unchanged. The following SEQ 0,0 gives out_err = 0 and result = 1.
- Reset mid-flight with 2 entries held under out_ready = 0: the cycle after reset has out_valid = 0, in_ready = 1 and true_count = 0. The next SNE with A=22, B=000A0021 gives result 1.
- Counter wrap: preload by issuing 65536 SEQ 5,5 transfers; true_count returns to 0x0000 and the next true result gives 0x0001.
